// File: rtl/maxpool2d.sv
// Fused ReLU + non-overlapping POOLxPOOL max-pool over every channel of a flat feature array.
// One window tap is examined per cycle; a pass is launched by start and closed by a done pulse.
module maxpool2d #(
   parameter int DATA_WIDTH = 16,
   parameter int CHANNELS   = 8,
   parameter int IMG_SIZE   = 28,
   parameter int POOL       = 2,
   parameter int RELU       = 1
) (
   input  logic                                                          clk,
   input  logic                                                          reset_n,
   input  logic                                                          start,
   input  logic [DATA_WIDTH*CHANNELS*IMG_SIZE*IMG_SIZE-1:0]              input_feature_flat,
   output logic [DATA_WIDTH*CHANNELS*(IMG_SIZE/POOL)*(IMG_SIZE/POOL)-1:0] out_feature_flat,
   output logic                                                          busy,
   output logic                                                          done
);

   localparam int OUT_SIZE  = IMG_SIZE / POOL;
   localparam int IN_WORDS  = CHANNELS * IMG_SIZE * IMG_SIZE;
   localparam int OUT_WORDS = CHANNELS * OUT_SIZE * OUT_SIZE;
   localparam int IN_AW     = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;
   localparam int OUT_AW    = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
   localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int OS_W      = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
   localparam int P_W       = $clog2(POOL);

   // ReLU is folded into the seed: starting the running max at zero clamps negative windows.
   localparam logic signed [DATA_WIDTH-1:0] SEED =
      (RELU != 0) ? '0 : {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      WRITE,
      FINISH
   } state_t;

   state_t state, state_next;

   logic [CH_W-1:0]                ch;
   logic [OS_W-1:0]                orow;
   logic [OS_W-1:0]                ocol;
   logic [P_W-1:0]                 pr;
   logic [P_W-1:0]                 pc;
   logic signed [DATA_WIDTH-1:0]   runmax;
   logic signed [DATA_WIDTH-1:0]   tap;
   logic signed [DATA_WIDTH-1:0]   in_words  [IN_WORDS];
   logic signed [DATA_WIDTH-1:0]   out_words [OUT_WORDS];
   logic [IN_AW-1:0]               tap_idx;
   logic [OUT_AW-1:0]              out_idx;
   logic                           accept;
   logic                           tap_last;
   logic                           win_last;
   logic                           ocol_last;
   logic                           orow_last;
   logic                           ch_last;

   genvar gi;
   generate
      for (gi = 0; gi < IN_WORDS; gi++) begin : g_in
         assign in_words[gi] = input_feature_flat[gi*DATA_WIDTH +: DATA_WIDTH];
      end
      for (gi = 0; gi < OUT_WORDS; gi++) begin : g_out
         assign out_feature_flat[gi*DATA_WIDTH +: DATA_WIDTH] = out_words[gi];
      end
   endgenerate

   // Address of the current tap inside the live input array and of the current output word.
   assign tap_idx = IN_AW'(32'(ch) * 32'(IMG_SIZE * IMG_SIZE)
                         + (32'(orow) * 32'(POOL) + 32'(pr)) * 32'(IMG_SIZE)
                         + 32'(ocol) * 32'(POOL) + 32'(pc));
   assign out_idx = OUT_AW'(32'(ch) * 32'(OUT_SIZE * OUT_SIZE)
                          + 32'(orow) * 32'(OUT_SIZE) + 32'(ocol));
   assign tap     = in_words[tap_idx];

   assign tap_last  = (pr == P_W'(POOL - 1)) && (pc == P_W'(POOL - 1));
   assign ocol_last = (ocol == OS_W'(OUT_SIZE - 1));
   assign orow_last = (orow == OS_W'(OUT_SIZE - 1));
   assign ch_last   = (ch == CH_W'(CHANNELS - 1));
   assign win_last  = ch_last && orow_last && ocol_last;

   // done is still high during the first IDLE cycle; blocking accept there drops a start raised with done.
   assign accept = (state == IDLE) && start && !done;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = SCAN;
         SCAN:    if (tap_last) state_next = WRITE;
         WRITE:   state_next = win_last ? FINISH : SCAN;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ch     <= '0;
         orow   <= '0;
         ocol   <= '0;
         pr     <= '0;
         pc     <= '0;
         runmax <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  ch     <= '0;
                  orow   <= '0;
                  ocol   <= '0;
                  pr     <= '0;
                  pc     <= '0;
                  runmax <= SEED;
               end
            end
            SCAN: begin
               if (tap > runmax) runmax <= tap;
               if (pc == P_W'(POOL - 1)) begin
                  pc <= '0;
                  pr <= (pr == P_W'(POOL - 1)) ? '0 : pr + P_W'(1);
               end else begin
                  pc <= pc + P_W'(1);
               end
            end
            WRITE: begin
               runmax <= SEED;
               if (ocol_last) begin
                  ocol <= '0;
                  if (orow_last) begin
                     orow <= '0;
                     ch   <= ch_last ? '0 : ch + CH_W'(1);
                  end else begin
                     orow <= orow + OS_W'(1);
                  end
               end else begin
                  ocol <= ocol + OS_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < OUT_WORDS; i++) out_words[i] <= '0;
      end else if (state == WRITE) begin
         out_words[out_idx] <= runmax;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         done <= 1'b0;
         busy <= 1'b0;
      end else begin
         done <= (state == FINISH);
         if (accept) begin
            busy <= 1'b1;
         end else if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule
